// File: rtl/weight_bias_loader.sv
// weight_bias_loader: decodes a 32-bit host command/payload stream and broadcasts
// weight and bias words with their target layer/neuron on the shared neuron config bus.
// Optional header range checking is compiled in with `define LOADER_RANGE_CHECK_EN.
module weight_bias_loader #(
  parameter int unsigned NUM_LAYERS  = 5,
  parameter int unsigned MAX_NEURONS = 30,
  parameter int unsigned MAX_WEIGHTS = 784,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic                 weightValid,
  output logic [31:0]          weightValue,
  output logic                 biasValid,
  output logic [31:0]          biasValue,
  output logic [31:0]          config_layer_num,
  output logic [31:0]          config_neuron_num,
  output logic                 busy,
  output logic                 load_done,
  output logic [CNT_WIDTH-1:0] words_loaded,
  output logic                 err
);

  typedef enum logic [1:0] {StHdr, StWgt, StBias, StSkip} state_e;

  localparam logic [1:0] KindNop  = 2'b00;
  localparam logic [1:0] KindWgt  = 2'b01;
  localparam logic [1:0] KindBias = 2'b10;
  localparam logic [1:0] KindEnd  = 2'b11;

  localparam logic [CNT_WIDTH-1:0] CntOne = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_e                r_state, w_state_d;
  logic [13:0]           r_remaining, w_remaining_d;
  logic                  r_ready;
  logic                  r_wvalid, r_bvalid, r_done, r_err;
  logic [31:0]           r_wvalue, r_bvalue, r_layer, r_neuron;
  logic [CNT_WIDTH-1:0]  r_words;

  logic                  w_accept;
  logic [1:0]            w_kind;
  logic [7:0]            w_layer, w_neuron;
  logic [13:0]           w_cnt;
  logic                  w_range_bad, w_illegal;
  logic                  w_wgt_stb, w_bias_stb, w_cfg_load, w_end, w_set_err;

  assign w_accept = s_valid & r_ready;
  assign w_kind   = s_data[31:30];
  assign w_layer  = s_data[23:16];
  assign w_neuron = s_data[15:8];
  assign w_cnt    = {s_data[29:24], s_data[7:0]};

  // Payload count only matters for WEIGHT; BIAS always carries a single word.
  assign w_range_bad = (w_layer == 8'd0)
                     || ({24'd0, w_layer} > NUM_LAYERS)
                     || ({24'd0, w_neuron} > MAX_NEURONS)
                     || ((w_kind == KindWgt) && ({18'd0, w_cnt} > MAX_WEIGHTS));

`ifdef LOADER_RANGE_CHECK_EN
  assign w_illegal = w_range_bad;
`else
  assign w_illegal = 1'b0;
  logic w_unused_range;
  assign w_unused_range = w_range_bad;
`endif

  // State and payload counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StHdr;
      r_remaining <= 14'd0;
    end else begin
      r_state     <= w_state_d;
      r_remaining <= w_remaining_d;
    end
  end

  // Header decode and payload sequencing.
  always_comb begin
    w_state_d     = r_state;
    w_remaining_d = r_remaining;
    w_wgt_stb     = 1'b0;
    w_bias_stb    = 1'b0;
    w_cfg_load    = 1'b0;
    w_end         = 1'b0;
    w_set_err     = 1'b0;
    unique case (r_state)
      StHdr: begin
        if (w_accept) begin
          unique case (w_kind)
            KindNop: ;
            KindWgt: begin
              if (w_illegal) begin
                w_set_err     = 1'b1;
                w_state_d     = StSkip;
                w_remaining_d = w_cnt;
              end else begin
                // A zero-length load still retargets the config bus.
                w_cfg_load = 1'b1;
                if (w_cnt != 14'd0) begin
                  w_state_d     = StWgt;
                  w_remaining_d = w_cnt;
                end
              end
            end
            KindBias: begin
              if (w_illegal) begin
                w_set_err     = 1'b1;
                w_state_d     = StSkip;
                w_remaining_d = 14'd1;
              end else begin
                w_cfg_load = 1'b1;
                w_state_d  = StBias;
              end
            end
            KindEnd: w_end = 1'b1;
            default: ;
          endcase
        end
      end
      StWgt: begin
        if (w_accept) begin
          w_wgt_stb     = 1'b1;
          w_remaining_d = r_remaining - 14'd1;
          if (r_remaining == 14'd1) w_state_d = StHdr;
        end
      end
      StBias: begin
        if (w_accept) begin
          w_bias_stb = 1'b1;
          w_state_d  = StHdr;
        end
      end
      StSkip: begin
        if (r_remaining == 14'd0) begin
          w_state_d = StHdr;
        end else if (w_accept) begin
          w_remaining_d = r_remaining - 14'd1;
          if (r_remaining == 14'd1) w_state_d = StHdr;
        end
      end
      default: w_state_d = StHdr;
    endcase
  end

  // Registered bus outputs: strobes land one cycle after the payload is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ready  <= 1'b0;
      r_wvalid <= 1'b0;
      r_bvalid <= 1'b0;
      r_wvalue <= 32'd0;
      r_bvalue <= 32'd0;
      r_layer  <= 32'd0;
      r_neuron <= 32'd0;
      r_done   <= 1'b0;
      r_words  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_ready  <= 1'b1;
      r_wvalid <= w_wgt_stb;
      r_bvalid <= w_bias_stb;
      r_done   <= w_end;
      if (w_wgt_stb)  r_wvalue <= s_data;
      if (w_bias_stb) r_bvalue <= s_data;
      if (w_cfg_load) begin
        r_layer  <= {24'd0, w_layer};
        r_neuron <= {24'd0, w_neuron};
      end
      if (w_end) begin
        r_words <= '0;
      end else if ((w_wgt_stb || w_bias_stb) && (r_words != '1)) begin
        r_words <= r_words + CntOne;
      end
      if (w_end) begin
        r_err <= 1'b0;
      end else if (w_set_err) begin
        r_err <= 1'b1;
      end
    end
  end

  assign s_ready           = r_ready;
  assign weightValid       = r_wvalid;
  assign weightValue       = r_wvalue;
  assign biasValid         = r_bvalid;
  assign biasValue         = r_bvalue;
  assign config_layer_num  = r_layer;
  assign config_neuron_num = r_neuron;
  assign busy              = (r_state != StHdr);
  assign load_done         = r_done;
  assign words_loaded      = r_words;
  assign err               = r_err;

endmodule

// File: tb/tb_weight_bias_loader.sv
// Bench for weight_bias_loader: a word-level reference model is compared against every
// DUT output on each falling edge, plus literal spot checks after each directed scenario.
module tb_weight_bias_loader;

  localparam int NumLayers  = 5;
  localparam int MaxNeurons = 30;
  localparam int MaxWeights = 784;
  localparam int CntMax     = 65535;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        weightValid, biasValid, busy, load_done, err;
  logic [31:0] weightValue, biasValue, config_layer_num, config_neuron_num;
  logic [15:0] words_loaded;

  int n_checks = 0;
  int n_errors = 0;

  weight_bias_loader dut (
    .clk               (clk),
    .rst               (rst),
    .s_data            (s_data),
    .s_valid           (s_valid),
    .s_ready           (s_ready),
    .weightValid       (weightValid),
    .weightValue       (weightValue),
    .biasValid         (biasValid),
    .biasValue         (biasValue),
    .config_layer_num  (config_layer_num),
    .config_neuron_num (config_neuron_num),
    .busy              (busy),
    .load_done         (load_done),
    .words_loaded      (words_loaded),
    .err               (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: what the bus must show, derived per accepted word.
  int          m_pending = 0;   // payload words still owed to the last header
  int          m_target  = 0;   // 0 weight, 1 bias, 2 discard
  bit          m_hold    = 0;   // discard entered with nothing to discard
  bit          m_ready = 0, m_wv = 0, m_bv = 0, m_done = 0, m_err = 0;
  logic [31:0] m_wval = 0, m_bval = 0, m_layer = 0, m_neuron = 0;
  int          m_words = 0;

  function automatic bit hdr_illegal(input logic [31:0] w);
`ifdef LOADER_RANGE_CHECK_EN
    int lay = int'(w[23:16]);
    int neu = int'(w[15:8]);
    int cnt = int'({w[29:24], w[7:0]});
    return lay == 0 || lay > NumLayers || neu > MaxNeurons ||
           (w[31:30] == 2'b01 && cnt > MaxWeights);
`else
    return w[31] & 1'b0;
`endif
  endfunction

  task automatic model_word(input logic [31:0] w);
    int cnt = int'({w[29:24], w[7:0]});
    if (m_hold) begin
      m_hold = 0;
    end else if (m_pending > 0) begin
      if (m_target == 0) begin
        m_wv = 1; m_wval = w;
      end else if (m_target == 1) begin
        m_bv = 1; m_bval = w;
      end
      if (m_target != 2 && m_words < CntMax) m_words++;
      m_pending--;
    end else begin
      case (w[31:30])
        2'b01, 2'b10: begin
          if (hdr_illegal(w)) begin
            m_err = 1; m_target = 2;
            m_pending = (w[31:30] == 2'b10) ? 1 : cnt;
            m_hold = (m_pending == 0);
          end else begin
            m_layer = {24'd0, w[23:16]}; m_neuron = {24'd0, w[15:8]};
            m_target = (w[31:30] == 2'b10) ? 1 : 0;
            m_pending = (w[31:30] == 2'b10) ? 1 : cnt;
          end
        end
        2'b11: begin m_done = 1; m_words = 0; m_err = 0; end
        default: ;
      endcase
    end
  endtask

  always @(posedge clk) begin
    bit was_hold = m_hold;
    m_wv = 0; m_bv = 0; m_done = 0;
    if (rst) begin
      m_ready = 0; m_pending = 0; m_hold = 0; m_err = 0; m_words = 0;
      m_wval = 0; m_bval = 0; m_layer = 0; m_neuron = 0;
    end else begin
      if (s_valid && m_ready) model_word(s_data);
      else if (was_hold) m_hold = 0;
      m_ready = 1;
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    chk("s_ready", {31'd0, s_ready}, {31'd0, m_ready});
    chk("weightValid", {31'd0, weightValid}, {31'd0, m_wv});
    chk("weightValue", weightValue, m_wval);
    chk("biasValid", {31'd0, biasValid}, {31'd0, m_bv});
    chk("biasValue", biasValue, m_bval);
    chk("layer", config_layer_num, m_layer);
    chk("neuron", config_neuron_num, m_neuron);
    chk("busy", {31'd0, busy}, {31'd0, (m_pending > 0 || m_hold)});
    chk("load_done", {31'd0, load_done}, {31'd0, m_done});
    chk("words_loaded", {16'd0, words_loaded}, m_words[31:0]);
    chk("err", {31'd0, err}, {31'd0, m_err});
  end

  task automatic put(input logic [31:0] w);
    s_valid = 1'b1;
    s_data  = w;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = 32'd0;
    idle(2);
    chk("rst_ready", {31'd0, s_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    idle(1);
    chk("ready_up", {31'd0, s_ready}, 32'd1);

    // 1: WEIGHT L2 N3 cnt4, back-to-back payload
    put(32'h4002_0304);
    for (int i = 0; i < 4; i++) put(32'h11 + i);
    chk("t1_wv", {31'd0, weightValid}, 32'd1);
    chk("t1_wval", weightValue, 32'h14);
    chk("t1_layer", config_layer_num, 32'd2);
    chk("t1_neuron", config_neuron_num, 32'd3);
    chk("t1_words", {16'd0, words_loaded}, 32'd4);
    chk("t1_busy", {31'd0, busy}, 32'd0);
    idle(1);

    // 2: BIAS L4 N6
    put(32'h8004_0600);
    put(32'h0000_0A00);
    chk("t2_bv", {31'd0, biasValid}, 32'd1);
    chk("t2_bval", biasValue, 32'h0A00);
    chk("t2_wv", {31'd0, weightValid}, 32'd0);
    chk("t2_layer", config_layer_num, 32'd4);
    chk("t2_words", {16'd0, words_loaded}, 32'd5);
    idle(1);

    // 5: END clears counters and pulses load_done
    put(32'hC000_0000);
    chk("t5_done", {31'd0, load_done}, 32'd1);
    chk("t5_words", {16'd0, words_loaded}, 32'd0);
    chk("t5_err", {31'd0, err}, 32'd0);
    idle(1);
    chk("t5_done_low", {31'd0, load_done}, 32'd0);

    // 3: WEIGHT L1 N0 cnt3 with two idle cycles between words
    put(32'h4001_0003);
    for (int i = 0; i < 3; i++) begin
      put(32'h300 + i);
      chk("t3_wv", {31'd0, weightValid}, 32'd1);
      idle(2);
      chk("t3_gap_wv", {31'd0, weightValid}, 32'd0);
      if (i < 2) chk("t3_gap_busy", {31'd0, busy}, 32'd1);
    end
    chk("t3_words", {16'd0, words_loaded}, 32'd3);

    // 4: reset in the middle of a 4-word load
    put(32'h4003_0104);
    put(32'hA1);
    put(32'hA2);
    rst = 1'b1;
    idle(2);
    chk("t4_wval", weightValue, 32'd0);
    chk("t4_layer", config_layer_num, 32'd0);
    chk("t4_words", {16'd0, words_loaded}, 32'd0);
    chk("t4_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    idle(1);
    // Decoded as a header (zero-length WEIGHT), never as leftover payload.
    put(32'h4000_0000);
    chk("t4_hdr_wv", {31'd0, weightValid}, 32'd0);
    idle(1);
    put(32'h8001_0200);
    put(32'h0000_BEEF);
    chk("t4_bv", {31'd0, biasValid}, 32'd1);
    chk("t4_bval", biasValue, 32'hBEEF);
    put(32'hC000_0000);
    idle(1);

    // 6: out-of-range layer 9
    put(32'h4009_0002);
    put(32'hAA);
    put(32'hBB);
`ifdef LOADER_RANGE_CHECK_EN
    chk("t6_err", {31'd0, err}, 32'd1);
    chk("t6_wv", {31'd0, weightValid}, 32'd0);
    chk("t6_layer", config_layer_num, 32'd1);
`else
    chk("t6_err", {31'd0, err}, 32'd0);
    chk("t6_wv", {31'd0, weightValid}, 32'd1);
    chk("t6_wval", weightValue, 32'hBB);
    chk("t6_layer", config_layer_num, 32'd9);
`endif
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
